// File: rtl/pcm_ctrl_pkg.sv
// Shared types and defaults for the PCM record/playback FIFO sequencer.
package pcm_ctrl_pkg;

  localparam int unsigned DBITS_DEF    = 8;
  localparam int unsigned CBITS_DEF    = 20;
  localparam int unsigned PLAY_DIV_DEF = 2083;
  localparam int unsigned SETTLE_DEF   = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RECORD  = 2'b01,
    ST_PLAY    = 2'b10,
    ST_MONITOR = 2'b11
  } pcm_state_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DIV_W_DEF = cnt_width(PLAY_DIV_DEF);

endpackage

// File: rtl/pcm_rate_tick.sv
// Free-running playback rate divider: one-cycle tick every DIV cycles,
// restart zeroes the count so the first tick lands DIV cycles later.
module pcm_rate_tick
  import pcm_ctrl_pkg::*;
#(
  parameter int unsigned DIV = PLAY_DIV_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q + CW'(1);
    tick_d = 1'b0;
    if (restart) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/pcm_fifo_ctrl.sv
// Record/playback sequencer between mic sampler, sample FIFO and audio out.
// Optional MONITOR state (simultaneous record + play) under PCM_FIFO_CTRL_MONITOR_EN.
module pcm_fifo_ctrl
  import pcm_ctrl_pkg::*;
#(
  parameter int unsigned DBITS    = DBITS_DEF,
  parameter int unsigned CBITS    = CBITS_DEF,
  parameter int unsigned PLAY_DIV = PLAY_DIV_DEF,
  parameter int unsigned SETTLE   = SETTLE_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_rec,
  input  logic             cmd_play,
  input  logic             cmd_stop,
  input  logic             mic_valid,
  input  logic [DBITS-1:0] mic_data,
  output logic             fifo_wr,
  output logic             fifo_rd,
  output logic [DBITS-1:0] fifo_din,
  input  logic [DBITS-1:0] fifo_dout,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  output logic [DBITS-1:0] pcm_out,
  output logic             pcm_valid,
  output logic [1:0]       state,
  output logic             overrun,
  output logic             underrun,
  output logic [CBITS-1:0] sample_count
);

  localparam int unsigned SW = cnt_width(SETTLE + 1);
  localparam logic [CBITS-1:0] CNT_MAX = '1;

  pcm_state_e       state_q, state_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [CBITS-1:0] count_q, count_d;
  logic             fifo_wr_q, fifo_wr_d;
  logic             fifo_rd_q, fifo_rd_d;
  logic [DBITS-1:0] fifo_din_q, fifo_din_d;
  logic [DBITS-1:0] pcm_out_q, pcm_out_d;
  logic             pcm_valid_q, pcm_valid_d;
  logic             cap_q, cap_d;
  logic             overrun_q, overrun_d;
  logic             underrun_q, underrun_d;
  logic             pend_q, pend_d;

  logic tick;
  logic enter_c, restart_c, settle_ok_c, tick_ev_c;
  logic do_wr, do_rd;

  assign enter_c     = !cmd_stop && (cmd_rec || cmd_play);
  assign restart_c   = enter_c || !((state_q == ST_PLAY) || (state_q == ST_MONITOR));
  assign settle_ok_c = (settle_q == '0);
  assign tick_ev_c   = tick || pend_q;

  pcm_rate_tick #(.DIV(PLAY_DIV)) u_rate (
    .clock   (clock),
    .reset   (reset),
    .restart (restart_c),
    .tick    (tick)
  );

  // Next state, strobes and counters; a tick that lands inside the settle
  // window is held in pend_q until the flags may be trusted again.
  always_comb begin
    state_d     = state_q;
    settle_d    = settle_ok_c ? settle_q : settle_q - SW'(1);
    count_d     = count_q;
    fifo_wr_d   = 1'b0;
    fifo_rd_d   = 1'b0;
    fifo_din_d  = fifo_din_q;
    pcm_out_d   = pcm_out_q;
    pcm_valid_d = 1'b0;
    cap_d       = fifo_rd_q;
    overrun_d   = overrun_q;
    underrun_d  = underrun_q;
    pend_d      = pend_q;
    do_wr       = 1'b0;
    do_rd       = 1'b0;

    // Read data arrives one cycle after the strobe, whatever the state does.
    if (cap_q) begin
      pcm_out_d   = fifo_dout;
      pcm_valid_d = 1'b1;
    end

    if (cmd_stop) begin
      state_d = ST_IDLE;
      pend_d  = 1'b0;
    end else if (enter_c) begin
      overrun_d  = 1'b0;
      underrun_d = 1'b0;
      pend_d     = 1'b0;
      if (cmd_rec && cmd_play) begin
`ifdef PCM_FIFO_CTRL_MONITOR_EN
        state_d = ST_MONITOR;
`else
        state_d = ST_RECORD;
`endif
      end else if (cmd_rec) begin
        state_d = ST_RECORD;
      end else begin
        state_d = ST_PLAY;
      end
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_RECORD: begin
          if (mic_valid) begin
            if (!settle_ok_c) begin
              overrun_d = 1'b1;
            end else if (fifo_full) begin
              overrun_d = 1'b1;
              state_d   = ST_IDLE;
            end else begin
              do_wr = 1'b1;
            end
          end
        end
        ST_PLAY: begin
          if (tick_ev_c) begin
            if (!settle_ok_c) begin
              pend_d = 1'b1;
            end else if (fifo_empty) begin
              underrun_d = 1'b1;
              state_d    = ST_IDLE;
              pend_d     = 1'b0;
            end else begin
              do_rd  = 1'b1;
              pend_d = 1'b0;
            end
          end
        end
`ifdef PCM_FIFO_CTRL_MONITOR_EN
        ST_MONITOR: begin
          if (mic_valid) begin
            if (!settle_ok_c) begin
              overrun_d = 1'b1;
            end else if (fifo_full) begin
              overrun_d = 1'b1;
              state_d   = ST_IDLE;
            end else begin
              do_wr = 1'b1;
            end
          end
          // A read sharing a cycle with a write needs two held samples.
          if (tick_ev_c && (state_d == ST_MONITOR)) begin
            if (!settle_ok_c) begin
              pend_d = 1'b1;
            end else if (fifo_empty) begin
              underrun_d = 1'b1;
              state_d    = ST_IDLE;
              pend_d     = 1'b0;
            end else if (do_wr && (count_q < CBITS'(2))) begin
              pend_d = 1'b0;
            end else begin
              do_rd  = 1'b1;
              pend_d = 1'b0;
            end
          end
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end

    if (do_wr) begin
      fifo_wr_d  = 1'b1;
      fifo_din_d = mic_data;
      settle_d   = SW'(SETTLE);
    end
    if (do_rd) begin
      fifo_rd_d = 1'b1;
      settle_d  = SW'(SETTLE);
    end

    case ({do_wr, do_rd})
      2'b10:   if (count_q != CNT_MAX) count_d = count_q + CBITS'(1);
      2'b01:   if (count_q != '0)      count_d = count_q - CBITS'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      settle_q    <= '0;
      count_q     <= '0;
      fifo_wr_q   <= 1'b0;
      fifo_rd_q   <= 1'b0;
      fifo_din_q  <= '0;
      pcm_out_q   <= '0;
      pcm_valid_q <= 1'b0;
      cap_q       <= 1'b0;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      count_q     <= count_d;
      fifo_wr_q   <= fifo_wr_d;
      fifo_rd_q   <= fifo_rd_d;
      fifo_din_q  <= fifo_din_d;
      pcm_out_q   <= pcm_out_d;
      pcm_valid_q <= pcm_valid_d;
      cap_q       <= cap_d;
      overrun_q   <= overrun_d;
      underrun_q  <= underrun_d;
      pend_q      <= pend_d;
    end
  end

  assign fifo_wr      = fifo_wr_q;
  assign fifo_rd      = fifo_rd_q;
  assign fifo_din     = fifo_din_q;
  assign pcm_out      = pcm_out_q;
  assign pcm_valid    = pcm_valid_q;
  assign state        = 2'(state_q);
  assign overrun      = overrun_q;
  assign underrun     = underrun_q;
  assign sample_count = count_q;

endmodule

// File: tb/tb_pcm_fifo_ctrl.sv
// Directed bench for pcm_fifo_ctrl with a behavioural FIFO; PLAY_DIV shortened to 16.
module tb_pcm_fifo_ctrl;

  localparam int unsigned DB  = 8;
  localparam int unsigned CB  = 20;
  localparam int unsigned DIV = 16;

  logic          clock, reset;
  logic          cmd_rec, cmd_play, cmd_stop, mic_valid;
  logic [DB-1:0] mic_data, fifo_din, fifo_dout, pcm_out;
  logic          fifo_wr, fifo_rd, fifo_full, fifo_empty, pcm_valid;
  logic [1:0]    state;
  logic          overrun, underrun;
  logic [CB-1:0] sample_count;

  pcm_fifo_ctrl #(.DBITS(DB), .CBITS(CB), .PLAY_DIV(DIV), .SETTLE(3)) dut (
    .clock(clock), .reset(reset), .cmd_rec(cmd_rec), .cmd_play(cmd_play),
    .cmd_stop(cmd_stop), .mic_valid(mic_valid), .mic_data(mic_data),
    .fifo_wr(fifo_wr), .fifo_rd(fifo_rd), .fifo_din(fifo_din),
    .fifo_dout(fifo_dout), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .pcm_out(pcm_out), .pcm_valid(pcm_valid), .state(state),
    .overrun(overrun), .underrun(underrun), .sample_count(sample_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural FIFO: data out one cycle after the read strobe.
  logic [DB-1:0] fq[$];
  int            fq_n = 0;
  logic          full_force = 1'b0;
  always @(posedge clock) begin
    if (reset) begin
      fq.delete();
      fifo_dout <= '0;
    end else begin
      if (fifo_wr) fq.push_back(fifo_din);
      if (fifo_rd && fq.size() != 0) fifo_dout <= fq.pop_front();
    end
    fq_n <= fq.size();
  end
  assign fifo_empty = (fq_n == 0);
  assign fifo_full  = full_force || (fq_n >= 64);

  // Event log sampled on the falling edge.
  logic [DB-1:0] wr_log[$];
  logic [DB-1:0] pv_dat[$];
  int            rd_cyc[$];
  int            pv_cyc[$];
  always @(negedge clock) begin
    if (!reset) begin
      if (fifo_wr) wr_log.push_back(fifo_din);
      if (fifo_rd) rd_cyc.push_back(cyc);
      if (pcm_valid) begin
        pv_cyc.push_back(cyc);
        pv_dat.push_back(pcm_out);
      end
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse_cmd(input logic r, input logic p, input logic s);
    cmd_rec = r; cmd_play = p; cmd_stop = s;
    @(negedge clock);
    cmd_rec = 1'b0; cmd_play = 1'b0; cmd_stop = 1'b0;
  endtask

  task automatic mic(input logic [DB-1:0] d, input logic exp_wr);
    mic_valid = 1'b1;
    mic_data  = d;
    @(negedge clock);
    mic_valid = 1'b0;
    chk_eq("mic_wr", 32'(fifo_wr), 32'(exp_wr));
    if (exp_wr) chk_eq("mic_din", 32'(fifo_din), 32'(d));
  endtask

  task automatic wait_rd(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (fifo_rd) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk_eq({tag, "_state"}, 32'(state), 32'd0);
    chk_eq({tag, "_wr"}, 32'(fifo_wr), 32'd0);
    chk_eq({tag, "_rd"}, 32'(fifo_rd), 32'd0);
    chk_eq({tag, "_din"}, 32'(fifo_din), 32'd0);
    chk_eq({tag, "_pcm"}, 32'(pcm_out), 32'd0);
    chk_eq({tag, "_pv"}, 32'(pcm_valid), 32'd0);
    chk_eq({tag, "_ovr"}, 32'(overrun), 32'd0);
    chk_eq({tag, "_udr"}, 32'(underrun), 32'd0);
    chk_eq({tag, "_cnt"}, 32'(sample_count), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int n0;
    logic [DB-1:0] exp_d[4];
    exp_d[0] = 8'd11; exp_d[1] = 8'd22; exp_d[2] = 8'd33; exp_d[3] = 8'd44;
    reset = 1'b1; cmd_rec = 1'b0; cmd_play = 1'b0; cmd_stop = 1'b0;
    mic_valid = 1'b0; mic_data = '0;
    repeat (3) @(negedge clock);
    chk_all_zero("reset");
    reset = 1'b0;
    @(negedge clock);

    // Record four samples ten cycles apart
    pulse_cmd(1'b1, 1'b0, 1'b0);
    chk_eq("rec_state", 32'(state), 32'd1);
    for (int i = 0; i < 4; i++) begin
      mic(exp_d[i], 1'b1);
      repeat (9) @(negedge clock);
    end
    chk_eq("rec_nwr", 32'(wr_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk_eq("rec_log", 32'(wr_log[i]), 32'(exp_d[i]));
    chk_eq("rec_cnt", 32'(sample_count), 32'd4);
    chk_eq("rec_ovr", 32'(overrun), 32'd0);

    // Play back until the FIFO runs dry
    rd_cyc.delete(); pv_cyc.delete(); pv_dat.delete();
    pulse_cmd(1'b0, 1'b1, 1'b0);
    chk_eq("play_state", 32'(state), 32'd2);
    for (int i = 0; i < 200 && state != 2'd0; i++) @(negedge clock);
    chk_eq("play_end_state", 32'(state), 32'd0);
    chk_eq("play_nrd", 32'(rd_cyc.size()), 32'd4);
    chk_eq("play_npv", 32'(pv_cyc.size()), 32'd4);
    for (int i = 0; i < 3 && i + 1 < rd_cyc.size(); i++)
      chk_eq("play_rd_gap", 32'(rd_cyc[i+1] - rd_cyc[i]), 32'(DIV));
    for (int i = 0; i < 4 && i < pv_cyc.size() && i < rd_cyc.size(); i++) begin
      chk_eq("play_pv_lat", 32'(pv_cyc[i] - rd_cyc[i]), 32'd2);
      chk_eq("play_pv_dat", 32'(pv_dat[i]), 32'(exp_d[i]));
    end
    chk_eq("play_udr", 32'(underrun), 32'd1);
    chk_eq("play_pcm_hold", 32'(pcm_out), 32'd44);
    chk_eq("play_cnt", 32'(sample_count), 32'd0);

    // Full FIFO drops the sample and aborts recording
    full_force = 1'b1;
    pulse_cmd(1'b1, 1'b0, 1'b0);
    chk_eq("full_udr_clr", 32'(underrun), 32'd0);
    mic(8'd99, 1'b0);
    chk_eq("full_ovr", 32'(overrun), 32'd1);
    chk_eq("full_state", 32'(state), 32'd0);
    full_force = 1'b0;

    // Sample arriving during the settle window is dropped
    pulse_cmd(1'b1, 1'b0, 1'b0);
    chk_eq("settle_ovr_clr", 32'(overrun), 32'd0);
    mic_valid = 1'b1; mic_data = 8'd55;
    @(negedge clock);
    chk_eq("settle_wr1", 32'(fifo_wr), 32'd1);
    mic_data = 8'd66;
    @(negedge clock);
    mic_valid = 1'b0;
    chk_eq("settle_wr2", 32'(fifo_wr), 32'd0);
    chk_eq("settle_ovr", 32'(overrun), 32'd1);
    chk_eq("settle_state", 32'(state), 32'd1);
    repeat (9) @(negedge clock);
    mic(8'd77, 1'b1);
    repeat (5) @(negedge clock);
    chk_eq("settle_cnt", 32'(sample_count), 32'd2);

    // Stop during a read: capture completes, then silence
    pulse_cmd(1'b0, 1'b1, 1'b0);
    wait_rd(40, ok);
    chk_eq("stop_rd_seen", 32'(ok), 32'd1);
    cmd_stop = 1'b1;
    @(negedge clock);
    cmd_stop = 1'b0;
    chk_eq("stop_state", 32'(state), 32'd0);
    @(negedge clock);
    chk_eq("stop_pv", 32'(pcm_valid), 32'd1);
    chk_eq("stop_pcm", 32'(pcm_out), 32'd55);
    @(negedge clock);
    n0 = rd_cyc.size() + wr_log.size() + pv_cyc.size();
    repeat (40) @(negedge clock);
    chk_eq("stop_quiet", 32'(rd_cyc.size() + wr_log.size() + pv_cyc.size() - n0), 32'd0);
    chk_eq("stop_cnt", 32'(sample_count), 32'd1);

    // Reset in the middle of playback
    pulse_cmd(1'b0, 1'b1, 1'b0);
    wait_rd(40, ok);
    chk_eq("rst_rd_seen", 32'(ok), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    chk_all_zero("midrst");
    reset = 1'b0;
    @(negedge clock);
    chk_eq("midrst_nopv", 32'(pcm_valid), 32'd0);

    // Stop outranks the other commands
    pulse_cmd(1'b1, 1'b1, 1'b1);
    chk_eq("prio_stop", 32'(state), 32'd0);
    pulse_cmd(1'b1, 1'b0, 1'b1);
    chk_eq("prio_stop_rec", 32'(state), 32'd0);

`ifdef PCM_FIFO_CTRL_MONITOR_EN
    // Coincident write and read in MONITOR with three samples held
    pulse_cmd(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      mic(8'(i), 1'b1);
      repeat (9) @(negedge clock);
    end
    chk_eq("mon_pre_cnt", 32'(sample_count), 32'd3);
    pulse_cmd(1'b1, 1'b1, 1'b0);
    chk_eq("mon_state", 32'(state), 32'd3);
    repeat (DIV) @(negedge clock);
    mic_valid = 1'b1; mic_data = 8'd4;
    @(negedge clock);
    mic_valid = 1'b0;
    chk_eq("mon_wr", 32'(fifo_wr), 32'd1);
    chk_eq("mon_rd", 32'(fifo_rd), 32'd1);
    chk_eq("mon_cnt", 32'(sample_count), 32'd3);
`else
    // Without MONITOR, rec+play together means RECORD
    pulse_cmd(1'b1, 1'b1, 1'b0);
    chk_eq("recplay_state", 32'(state), 32'd1);
    mic(8'd88, 1'b1);
    chk_eq("recplay_cnt", 32'(sample_count), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
